// File: rtl/bus_rr_xbar_pkg.sv
// Shared types and constants for the round-robin bus interconnect.
// Default decode windows cover the SoC memory and peripheral slots.
package bus_rr_xbar_pkg;

    localparam int XBAR_MAX_PORTS = 8;

    typedef enum logic [1:0] {
        XS_IDLE   = 2'd0,
        XS_ACCESS = 2'd1,
        XS_RESP   = 2'd2,
        XS_ERR    = 2'd3
    } xbar_state_e;

    localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
    localparam logic [31:0] MEM_MASK    = 32'hF000_0000;
    localparam logic [31:0] PERIPH_BASE = 32'h1000_0000;
    localparam logic [31:0] PERIPH_MASK = 32'hF000_0000;

    // Index width that stays legal when a port count is 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_rr_xbar_rr_arbiter.sv
// Combinational round-robin picker: the first requester after 'last',
// scanning upward with wrap-around.
module rr_arbiter
    import bus_rr_xbar_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic          en,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        if (en) begin
            for (int k = 1; k <= N; k++) begin
                cand = IW'((int'(last) + k) % N);
                if (!any && req[cand]) begin
                    any     = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

endmodule

// File: rtl/bus_rr_xbar.sv
// Shared-bus interconnect: NM masters, NS slaves, one transaction in flight,
// round-robin grant, base/mask decode, timeout and decode-error responses.
module bus_rr_xbar
    import bus_rr_xbar_pkg::*;
#(
    parameter int NM = 2,
    parameter int NS = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [NS-1:0][AW-1:0] S_BASE = {32'h1000_0000, 32'h0000_0000},
    parameter logic [NS-1:0][AW-1:0] S_MASK = {32'hF000_0000, 32'hF000_0000},
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NM-1:0]                m_req,
    input  logic [NM-1:0][DW/8-1:0]      m_we,
    input  logic [NM-1:0][AW-1:0]        m_addr,
    input  logic [NM-1:0][DW-1:0]        m_wdata,
    output logic [NM-1:0]                m_rvalid,
    output logic [NM-1:0][DW-1:0]        m_rdata,
    output logic [NM-1:0]                m_err,
    output logic [NS-1:0]                s_req,
    output logic [DW/8-1:0]              s_we,
    output logic [AW-1:0]                s_addr,
    output logic [DW-1:0]                s_wdata,
    input  logic [NS-1:0][DW-1:0]        s_rdata,
    input  logic [NS-1:0]                s_ready
);

    localparam int BW  = DW / 8;
    localparam int MIW = idx_w(NM);
    localparam int SIW = idx_w(NS);
    localparam int CW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] IDLE   = XS_IDLE;
    localparam logic [1:0] ACCESS = XS_ACCESS;
    localparam logic [1:0] RESP   = XS_RESP;
    localparam logic [1:0] ERR    = XS_ERR;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [1:0]     state;
    logic [MIW-1:0] last_gnt;
    logic [MIW-1:0] gnt_idx;
    logic           arb_any;
    logic [SIW:0]   dec;

    logic [MIW-1:0] idx_p1;
    logic [SIW-1:0] sel_p1;
    logic [CW-1:0]  cnt_p1;
    logic [AW-1:0]  addr_p1;
    logic [BW-1:0]  we_p1;
    logic [DW-1:0]  wdata_p1;

    // Returns {hit, index}; the lowest matching slave wins.
    function automatic logic [SIW:0] decode_slave(input logic [AW-1:0] a);
        logic [SIW:0] r;
        r = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((a & S_MASK[i]) == S_BASE[i]) r = {1'b1, SIW'(i)};
        end
        return r;
    endfunction

    rr_arbiter #(.N(NM)) u_arb (
        .req     (m_req),
        .last    (last_gnt),
        .en      (state == IDLE),
        .gnt_idx (gnt_idx),
        .any     (arb_any)
    );

    assign dec = decode_slave(m_addr[gnt_idx]);

    // Stage p1: request fields latched at grant, held for the whole access.
    always_ff @(posedge clk) begin
        if (arb_any) begin
            addr_p1  <= m_addr[gnt_idx];
            we_p1    <= m_we[gnt_idx];
            wdata_p1 <= m_wdata[gnt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= MIW'(NM - 1);
            idx_p1   <= '0;
            sel_p1   <= '0;
            cnt_p1   <= '0;
            m_rvalid <= '0;
            m_rdata  <= '0;
            m_err    <= '0;
        end else begin
            m_rvalid <= '0;
            m_rdata  <= '0;
            m_err    <= '0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        idx_p1 <= gnt_idx;
                        cnt_p1 <= '0;
                        if (dec[SIW]) begin
                            sel_p1 <= dec[SIW-1:0];
                            state  <= ACCESS;
                        end else begin
                            m_rvalid[gnt_idx] <= 1'b1;
                            m_err[gnt_idx]    <= 1'b1;
                            state             <= ERR;
                        end
                    end
                end
                ACCESS: begin
                    if (s_ready[sel_p1]) begin
                        m_rvalid[idx_p1] <= 1'b1;
                        m_rdata[idx_p1]  <= s_rdata[sel_p1];
                        state            <= RESP;
                    end else if (cnt_p1 == CNT_LAST) begin
                        m_rvalid[idx_p1] <= 1'b1;
                        m_err[idx_p1]    <= 1'b1;
                        state            <= ERR;
                    end else begin
                        cnt_p1 <= cnt_p1 + 1'b1;
                    end
                end
                RESP, ERR: begin
                    last_gnt <= idx_p1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave side is driven only while an access is live, so reset drops it at once.
    assign s_req   = (state == ACCESS) ? (NS'(1) << sel_p1) : '0;
    assign s_addr  = (state == ACCESS) ? addr_p1  : '0;
    assign s_we    = (state == ACCESS) ? we_p1    : '0;
    assign s_wdata = (state == ACCESS) ? wdata_p1 : '0;

endmodule

// File: tb/tb_bus_rr_xbar.sv
// Scoreboard bench for bus_rr_xbar: two masters, two scripted slaves.
module tb_bus_rr_xbar;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          m_req;
    logic [1:0][3:0]     m_we;
    logic [1:0][31:0]    m_addr;
    logic [1:0][31:0]    m_wdata;
    logic [1:0]          m_rvalid;
    logic [1:0][31:0]    m_rdata;
    logic [1:0]          m_err;
    logic [1:0]          s_req;
    logic [3:0]          s_we;
    logic [31:0]         s_addr;
    logic [31:0]         s_wdata;
    logic [1:0][31:0]    s_rdata;
    logic [1:0]          s_ready;

    logic [7:0]  s_wait [2];
    logic [7:0]  acc_cnt [2];
    logic [31:0] s_base [2];
    logic        rdy0_force;
    int          cyc = 0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    bus_rr_xbar #(
        .NM(2), .NS(2), .AW(32), .DW(32),
        .S_BASE({32'h1000_0000, 32'h0000_0000}),
        .S_MASK({32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slaves: data is a per-slave base XOR the bus address; ready after s_wait cycles.
    always @(posedge clk) begin
        acc_cnt[0] <= s_req[0] ? acc_cnt[0] + 8'd1 : 8'd0;
        acc_cnt[1] <= s_req[1] ? acc_cnt[1] + 8'd1 : 8'd0;
    end
    assign s_rdata = {s_base[1] ^ s_addr, s_base[0] ^ s_addr};
    assign s_ready = {s_req[1] && (acc_cnt[1] == s_wait[1]),
                      (s_req[0] && (acc_cnt[0] == s_wait[0])) || rdy0_force};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string p);
        chk({p, "_s_req"},    64'(s_req),    64'd0);
        chk({p, "_m_rvalid"}, 64'(m_rvalid), 64'd0);
        chk({p, "_m_err"},    64'(m_err),    64'd0);
        chk({p, "_m_rdata"},  64'(m_rdata),  64'd0);
        chk({p, "_s_addr"},   64'(s_addr),   64'd0);
        chk({p, "_s_we"},     64'(s_we),     64'd0);
        chk({p, "_s_wdata"},  64'(s_wdata),  64'd0);
    endtask

    task automatic start(input int m, input logic [31:0] a, input logic [3:0] we,
                         input logic [31:0] wd);
        m_addr[m]  = a;
        m_we[m]    = we;
        m_wdata[m] = wd;
        m_req[m]   = 1'b1;
    endtask

    // Waits for master m's response, counting cycles with any s_req high.
    task automatic wait_done(input int m, output int hi);
        bit seen;
        seen = 1'b0;
        hi   = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (s_req != 2'b00) hi++;
            if (m_rvalid[m]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("wait_rvalid_bound", 64'd0, 64'd1);
        m_req[m] = 1'b0;
    endtask

    // Response monitor: every m_rvalid must match the oldest expectation.
    exp_t             me;
    logic [1:0][31:0] ev;
    logic [1:0]       ov;
    logic [1:0]       oe;
    always @(posedge clk) begin
        #1;
        if (m_rvalid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 64'(m_rvalid), 64'd0);
            end else begin
                me = sb.pop_front();
                ev = '0;
                ov = '0;
                oe = '0;
                ev[me.idx] = me.rdata;
                ov[me.idx] = 1'b1;
                oe[me.idx] = me.err;
                chk("resp_rvalid",  64'(m_rvalid), 64'(ov));
                chk("resp_rdata",   64'(m_rdata),  64'(ev));
                chk("resp_err",     64'(m_err),    64'(oe));
                chk("resp_latency", 64'(cyc),      64'(me.cyc));
            end
        end
    end

    initial begin
        int k;
        int hi;
        int seen;
        rst        = 1'b1;
        m_req      = '0;
        m_we       = '0;
        m_addr     = '0;
        m_wdata    = '0;
        rdy0_force = 1'b0;
        s_wait[0]  = 8'd0;
        s_wait[1]  = 8'd0;
        s_base[0]  = 32'h0;
        s_base[1]  = 32'h0;
        repeat (3) tick();
        chk_quiet("reset");
        rst = 1'b0;
        tick();

        // Zero-wait read from slave 0.
        s_base[0] = 32'hDEAD_BEEF ^ 32'h0000_0010;
        k = cyc;
        start(0, 32'h0000_0010, 4'b0000, 32'h0);
        sb.push_back('{0, 32'hDEAD_BEEF, 1'b0, k + 2});
        tick();
        chk("zw_s_req",  64'(s_req),  64'b01);
        chk("zw_s_addr", 64'(s_addr), 64'h10);
        chk("zw_s_we",   64'(s_we),   64'h0);
        wait_done(0, hi);
        tick();

        // Write with three wait states; master fields change mid-access,
        // and a stray ready from the idle slave must be ignored.
        s_wait[1]  = 8'd3;
        s_base[1]  = 32'hCAFE_0000;
        rdy0_force = 1'b1;
        k = cyc;
        start(1, 32'h1000_0004, 4'b0011, 32'h1234_5678);
        sb.push_back('{1, 32'hCAFE_0000 ^ 32'h1000_0004, 1'b0, k + 5});
        for (int a = 1; a <= 4; a++) begin
            tick();
            chk("wr_s_req",   64'(s_req),   64'b10);
            chk("wr_s_addr",  64'(s_addr),  64'h1000_0004);
            chk("wr_s_we",    64'(s_we),    64'b0011);
            chk("wr_s_wdata", 64'(s_wdata), 64'h1234_5678);
            if (a == 1) begin
                m_addr[1]  = 32'h1000_0FF0;
                m_we[1]    = 4'hF;
                m_wdata[1] = 32'h0;
            end
        end
        wait_done(1, hi);
        rdy0_force = 1'b0;
        s_wait[1]  = 8'd0;
        tick();

        // Unmapped address: decode error, no slave touched.
        k = cyc;
        start(0, 32'h2000_0000, 4'b0000, 32'h0);
        sb.push_back('{0, 32'h0, 1'b1, k + 1});
        wait_done(0, hi);
        chk("dec_no_s_req", 64'(hi), 64'd0);
        tick();

        // Slave 0 never ready: timeout after 16 access cycles.
        s_wait[0] = 8'd255;
        k = cyc;
        start(0, 32'h0000_0100, 4'b0000, 32'h0);
        sb.push_back('{0, 32'h0, 1'b1, k + 17});
        wait_done(0, hi);
        chk("to_s_req_cycles", 64'(hi), 64'd16);
        tick();
        chk("to_idle_s_req", 64'(s_req), 64'd0);
        s_wait[0] = 8'd0;

        // Reset during a wait state aborts with no response.
        s_wait[1] = 8'd10;
        start(1, 32'h1000_0008, 4'hF, 32'hA5A5_A5A5);
        tick();
        tick();
        chk("rma_in_access", 64'(s_req), 64'b10);
        rst   = 1'b1;
        m_req = '0;
        tick();
        chk_quiet("rma");
        tick();
        rst       = 1'b0;
        s_wait[1] = 8'd0;
        tick();

        // Both masters request continuously: m0 first after reset, then alternate.
        s_base[0] = 32'h5555_0000;
        m_addr[0] = 32'h0000_0020;
        m_addr[1] = 32'h0000_0030;
        m_we      = '0;
        k = cyc;
        m_req = 2'b11;
        sb.push_back('{0, 32'h5555_0020, 1'b0, k + 2});
        sb.push_back('{1, 32'h5555_0030, 1'b0, k + 5});
        sb.push_back('{0, 32'h5555_0020, 1'b0, k + 8});
        sb.push_back('{1, 32'h5555_0030, 1'b0, k + 11});
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_rvalid != 2'b00) seen++;
            if (seen == 4) break;
        end
        m_req = '0;
        chk("rr_responses", 64'(seen), 64'd4);
        tick();
        tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
